auth_blk_p: RTL and testbench
=============================

# auth_blk_p

Parametrised successor to the Segway authorisation block. It consumes command bytes from the UART receiver (`rx_data`/`rx_rdy`) and drives `pwr_up` to the balance controller and motor drive. Compared with the fixed 'g'/'s' authoriser it adds:
- configurable command codes
- a debounced `rider_off` qualifier
- an idle auto-power-down timer
- error and timeout status pulses

It sits between the UART receiver and the `en_steer`/balance-control logic.

## Interface
- `GO_CMD`, default 8'h67 — byte that powers up.
- `STOP_CMD`, default 8'h73 — byte that requests power-down.
- `OFF_DB`, default 4 — consecutive `rider_off`-high cycles required before rider counts as off (≥1).
- `IDLE_TO`, default 67108864 — cycles of debounced rider-off while powered before auto power-down (≥2).
- `CNT_W`, default $clog2(IDLE_TO+1) — idle counter width.

- `clk` input 1 — system clock, all logic on posedge.
- `rst` input 1 — asynchronous, active-high reset.
- `rx_data` input 8 — received byte, valid while `rx_rdy` high.
- `rx_rdy` input 1 — level; byte available, held until cleared.
- `rider_off` input 1 — raw rider-off indication from load-cell compare.
- `clr_rx_rdy` output 1 — one-cycle pulse acknowledging a consumed byte.
- `pwr_up` output 1 — Segway powered, registered.
- `stop_pend` output 1 — STOP received, waiting for rider to dismount.
- `cmd_err` output 1 — one-cycle pulse, unrecognised byte consumed.
- `timeout_pd` output 1 — one-cycle pulse, idle auto power-down occurred.

## Operation
- **Byte accept:** `take = rx_rdy & ~clr_rx_rdy`. On `take`, `clr_rx_rdy` is registered high for exactly one cycle, so each byte is consumed once.
- **Debounce:**
  - Saturating counter `db` increments while `rider_off`=1 and clears to 0 on any `rider_off`=0.
  - `off_q = (db == OFF_DB)`.
- **States** (`pwr_up = state != OFF`, `stop_pend = state == STOP_WAIT`):
  - **OFF:** `take` & GO → ON. `take` & STOP → stay, no error. `take` & other → stay, `cmd_err`.
  - **ON:**
    - `take` & STOP & `off_q` → OFF.
    - `take` & STOP & ~`off_q` → STOP_WAIT.
    - `take` & GO → stay.
    - `take` & other → `cmd_err`.
    - Idle counter reaching `IDLE_TO`-1 with `off_q` and no `take` → OFF, `timeout_pd` pulse.
  - **STOP_WAIT:**
    - `off_q` and no `take` → OFF.
    - `take` & GO → ON (stop cancelled, takes priority over `off_q`).
    - `take` & STOP → stay.
    - `take` & other → `cmd_err`, stay unless `off_q`.
- **Idle counter:**
  - Counts only in ON while `off_q`=1.
  - Clears on ~`off_q`, on any `take`, and in OFF/STOP_WAIT.
  - Saturates; never wraps.
- **Priority in one cycle:** `take` beats timeout and beats `off_q` in STOP_WAIT, except STOP+`off_q` in ON.

## Timing
- **Reset values:** state OFF, `pwr_up`=0, `stop_pend`=0, `clr_rx_rdy`=0, `cmd_err`=0, `timeout_pd`=0, `db`=0, idle counter 0.
- **Response latency:**
  - `pwr_up`, `stop_pend`, `clr_rx_rdy` and `cmd_err` change on the clock edge that samples `take`, i.e. 1 cycle after `rx_rdy` rises.
  - `pwr_up` falls 1 cycle after `off_q` rises in STOP_WAIT.
- **Debounce latency:** `off_q` rises `OFF_DB` edges after `rider_off` rises.
- **Timeout latency:** `timeout_pd` and the `pwr_up` fall occur `IDLE_TO` edges after `off_q` rises in ON, absent bytes.
- **Reset mid-operation:** asynchronous return to reset values. A pending `rx_rdy` is accepted on the first edge after reset deasserts.

## Structure
- **Package `auth_pkg`:**
  - state enum `auth_state_t` {OFF, ON, STOP_WAIT}
  - localparams `GO_DEF` = 8'h67, `STOP_DEF` = 8'h73
- **Sub-module `rider_db`:**
  - parameter `OFF_DB`
  - ports `clk`, `rst`, `rider_off` → `off_q`
- The FSM and idle counter live in the top module.

## Test plan
- **Reset and GO:** reset, then `rx_data`=8'h67 with `rx_rdy`.
  - `clr_rx_rdy` pulses once.
  - `pwr_up`=1 one cycle later.
  - `cmd_err`=0.
- **STOP with rider on:** in ON, `rider_off`=0, send 8'h73.
  - `stop_pend`=1, `pwr_up` stays 1.
  - Raise `rider_off`: `pwr_up`=0 exactly `OFF_DB`+1 cycles later.
- **STOP cancelled:** in STOP_WAIT send 8'h67 → ON, `stop_pend`=0.
  - Glitch `rider_off` high for `OFF_DB`-1 cycles → `pwr_up` remains 1.
- **Bad byte:** send 8'h41 in OFF and in ON.
  - `cmd_err` pulses one cycle each time.
  - State unchanged.
  - `clr_rx_rdy` pulses.
- **Idle timeout:** `IDLE_TO`=100, `OFF_DB`=4, in ON hold `rider_off`=1.
  - `timeout_pd` pulses and `pwr_up`=0 at cycle 104.
  - Repeat with GO byte sent at cycle 50: timeout moves to cycle 150.
- **Async reset mid-STOP_WAIT:** assert `rst` between edges.
  - All outputs 0 immediately.
  - Held `rx_rdy` with 8'h67 accepted on the first post-reset edge.

Source files
------------

// File: rtl/auth_blk_p_pkg.sv
// auth_pkg: shared types and default command codes for the authorisation
// block (auth_blk_p) and its bench.
//   auth_state_t : OFF / ON / STOP_WAIT power-state encoding
//   GO_DEF       : default power-up command byte ('g')
//   STOP_DEF     : default power-down request byte ('s')
package auth_pkg;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    ON        = 2'd1,
    STOP_WAIT = 2'd2
  } auth_state_t;

  localparam logic [7:0] GO_DEF   = 8'h67;
  localparam logic [7:0] STOP_DEF = 8'h73;

endpackage

// File: rtl/auth_blk_p_if.sv
// auth_blk_p_if: byte handshake between the UART receiver and the
// authorisation block.
//   rx_data    : received byte, valid while rx_rdy is high
//   rx_rdy     : level, byte available until acknowledged
//   clr_rx_rdy : one-cycle acknowledge from the consumer
// Modports: master = UART receiver side, slave = authorisation block side.
interface auth_blk_p_if;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       clr_rx_rdy;

  modport master (output rx_data, output rx_rdy, input clr_rx_rdy);
  modport slave  (input rx_data, input rx_rdy, output clr_rx_rdy);
endinterface

// File: rtl/auth_blk_p_rider_db.sv
// rider_db: debounces the raw rider-off indication.
//   clk, rst  : clock, asynchronous active-high reset
//   rider_off : raw indication from the load-cell compare
//   off_q     : high once rider_off has been high OFF_DB consecutive cycles
module rider_db #(
  parameter int OFF_DB = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic rider_off,
  output logic off_q
);

  localparam int            DB_W   = $clog2(OFF_DB + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(OFF_DB);

  logic [DB_W-1:0] r_db;

  // Saturating run-length counter; any low sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_db <= '0;
    else if (!rider_off)    r_db <= '0;
    else if (r_db != DB_MAX) r_db <= r_db + DB_W'(1);
  end

  assign off_q = (r_db == DB_MAX);

endmodule

// File: rtl/auth_blk_p.sv
// auth_blk_p: Segway power authorisation. Consumes command bytes from the
// UART receiver and drives pwr_up to the balance controller / motor drive.
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : byte handshake (slave side: rx_data, rx_rdy -> clr_rx_rdy)
//   rider_off  : raw rider-off indication (debounced internally)
//   pwr_up     : Segway powered
//   stop_pend  : STOP received, waiting for the rider to step off
//   cmd_err    : one-cycle pulse, unrecognised byte consumed
//   timeout_pd : one-cycle pulse, idle auto power-down
module auth_blk_p
  import auth_pkg::*;
#(
  parameter logic [7:0] GO_CMD   = GO_DEF,
  parameter logic [7:0] STOP_CMD = STOP_DEF,
  parameter int         OFF_DB   = 4,
  parameter int         IDLE_TO  = 67108864,
  parameter int         CNT_W    = $clog2(IDLE_TO + 1)
) (
  input  logic         clk,
  input  logic         rst,
  auth_blk_p_if.slave  rx,
  input  logic         rider_off,
  output logic         pwr_up,
  output logic         stop_pend,
  output logic         cmd_err,
  output logic         timeout_pd
);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TO - 1);

  auth_state_t      r_state, w_nxt;
  logic             r_clr, r_err, r_tpd, r_pwr, r_stop;
  logic [CNT_W-1:0] r_idle;
  logic             w_take, w_off_q, w_is_go, w_is_stop, w_err, w_tpd;

  rider_db #(.OFF_DB(OFF_DB)) u_db (
    .clk       (clk),
    .rst       (rst),
    .rider_off (rider_off),
    .off_q     (w_off_q)
  );

  // A byte is taken only when the previous acknowledge is not still
  // asserted, so a level rx_rdy is consumed exactly once.
  assign w_take    = rx.rx_rdy & ~r_clr;
  assign w_is_go   = (rx.rx_data == GO_CMD);
  assign w_is_stop = (rx.rx_data == STOP_CMD);

  always_comb begin
    w_nxt = r_state;
    w_err = 1'b0;
    w_tpd = 1'b0;
    unique case (r_state)
      OFF: begin
        if (w_take) begin
          if (w_is_go)         w_nxt = ON;
          else if (!w_is_stop) w_err = 1'b1;
        end
      end
      ON: begin
        if (w_take) begin
          if (w_is_stop)     w_nxt = w_off_q ? OFF : STOP_WAIT;
          else if (!w_is_go) w_err = 1'b1;
        end else if (w_off_q && r_idle == IDLE_LAST) begin
          w_nxt = OFF;
          w_tpd = 1'b1;
        end
      end
      STOP_WAIT: begin
        // A byte in flight wins over a rider that has just stepped off,
        // so a late GO still cancels the stop.
        if (w_take) begin
          if (w_is_go) w_nxt = ON;
          else if (!w_is_stop) begin
            w_err = 1'b1;
            if (w_off_q) w_nxt = OFF;
          end
        end else if (w_off_q) begin
          w_nxt = OFF;
        end
      end
      default: w_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OFF;
      r_clr   <= 1'b0;
      r_err   <= 1'b0;
      r_tpd   <= 1'b0;
      r_pwr   <= 1'b0;
      r_stop  <= 1'b0;
      r_idle  <= '0;
    end else begin
      r_state <= w_nxt;
      r_clr   <= w_take;
      r_err   <= w_err;
      r_tpd   <= w_tpd;
      r_pwr   <= (w_nxt != OFF);
      r_stop  <= (w_nxt == STOP_WAIT);
      // Idle time accumulates only while powered with the rider off and
      // no traffic; it holds at its last value rather than wrapping.
      if (r_state == ON && w_off_q && !w_take)
        r_idle <= (r_idle == IDLE_LAST) ? r_idle : r_idle + CNT_W'(1);
      else
        r_idle <= '0;
    end
  end

  assign rx.clr_rx_rdy = r_clr;
  assign pwr_up        = r_pwr;
  assign stop_pend     = r_stop;
  assign cmd_err       = r_err;
  assign timeout_pd    = r_tpd;

endmodule

// File: tb/tb_auth_blk_p.sv
// Directed bench for auth_blk_p (OFF_DB=4, IDLE_TO=100).
module tb_auth_blk_p;
  import auth_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rider_off;
  logic pwr_up, stop_pend, cmd_err, timeout_pd;
  int   checks   = 0;
  int   failures = 0;

  auth_blk_p_if bus ();

  auth_blk_p #(
    .GO_CMD   (8'h67),
    .STOP_CMD (8'h73),
    .OFF_DB   (4),
    .IDLE_TO  (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (bus),
    .rider_off  (rider_off),
    .pwr_up     (pwr_up),
    .stop_pend  (stop_pend),
    .cmd_err    (cmd_err),
    .timeout_pd (timeout_pd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       exp_pwr;
    logic       exp_stop;
    logic       exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Present a byte, hold rx_rdy across two edges, expect a single accept.
  task automatic send(input logic [7:0] b, input logic ep, input logic es,
                      input logic ee, input string nm);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    step();
    chk({nm, " clr"},  bus.clr_rx_rdy, 1);
    chk({nm, " pwr"},  pwr_up, ep);
    chk({nm, " stop"}, stop_pend, es);
    chk({nm, " err"},  cmd_err, ee);
    step();
    chk({nm, " clr_once"}, bus.clr_rx_rdy, 0);
    chk({nm, " err_once"}, cmd_err, 0);
    chk({nm, " pwr_hold"}, pwr_up, ep);
    bus.rx_rdy = 1'b0;
  endtask

  // Hold rider_off high from edge 1 in ON; optional GO byte taken at edge go_at.
  task automatic idle_run(input int go_at, input int exp_edge, input string nm);
    int   hit   = 0;
    logic early = 1'b0;
    logic pw_at = 1'b1;
    rider_off = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      if (n == go_at) begin
        bus.rx_data = 8'h67;
        bus.rx_rdy  = 1'b1;
      end
      if (n == go_at + 1) bus.rx_rdy = 1'b0;
      step();
      if (timeout_pd) begin
        hit   = n;
        pw_at = pwr_up;
        break;
      end
      if (!pwr_up) early = 1'b1;
    end
    chk({nm, " edge"},      hit, exp_edge);
    chk({nm, " early_off"}, early, 0);
    chk({nm, " pwr"},       pw_at, 0);
    step();
    chk({nm, " pulse_len"}, timeout_pd, 0);
    rider_off = 1'b0;
    step();
  endtask

  initial begin
    tbl[0]  = '{8'h41, 1'b0, 1'b0, 1'b1};  // bad byte in OFF
    tbl[1]  = '{8'h73, 1'b0, 1'b0, 1'b0};  // STOP in OFF: ignored
    tbl[2]  = '{8'h67, 1'b1, 1'b0, 1'b0};  // GO -> ON
    tbl[3]  = '{8'h41, 1'b1, 1'b0, 1'b1};  // bad byte in ON
    tbl[4]  = '{8'h67, 1'b1, 1'b0, 1'b0};  // GO in ON
    tbl[5]  = '{8'h73, 1'b1, 1'b1, 1'b0};  // STOP, rider on -> STOP_WAIT
    tbl[6]  = '{8'h73, 1'b1, 1'b1, 1'b0};  // STOP in STOP_WAIT
    tbl[7]  = '{8'h41, 1'b1, 1'b1, 1'b1};  // bad byte in STOP_WAIT
    tbl[8]  = '{8'h67, 1'b1, 1'b0, 1'b0};  // GO cancels stop
    tbl[9]  = '{8'h73, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{8'h67, 1'b1, 1'b0, 1'b0};

    rst         = 1'b1;
    rider_off   = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_rdy  = 1'b0;
    step();
    step();
    chk("reset pwr",  pwr_up, 0);
    chk("reset stop", stop_pend, 0);
    chk("reset clr",  bus.clr_rx_rdy, 0);
    chk("reset err",  cmd_err, 0);
    chk("reset tpd",  timeout_pd, 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++)
      send(tbl[i].data, tbl[i].exp_pwr, tbl[i].exp_stop, tbl[i].exp_err,
           $sformatf("vec%0d", i));

    // STOP with rider on, then rider steps off: OFF on edge OFF_DB+1.
    send(8'h73, 1'b1, 1'b1, 1'b0, "stopwait");
    rider_off = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      step();
      if (n == 4) chk("sw pwr_before", pwr_up, 1);
      if (n == 5) begin
        chk("sw pwr_off",  pwr_up, 0);
        chk("sw stop_off", stop_pend, 0);
      end
    end
    rider_off = 1'b0;
    step();

    // Short glitch in STOP_WAIT must not power down.
    send(8'h67, 1'b1, 1'b0, 1'b0, "glitch_go");
    send(8'h73, 1'b1, 1'b1, 1'b0, "glitch_stop");
    rider_off = 1'b1;
    repeat (3) step();
    rider_off = 1'b0;
    repeat (3) step();
    chk("glitch pwr",  pwr_up, 1);
    chk("glitch stop", stop_pend, 1);
    send(8'h67, 1'b1, 1'b0, 1'b0, "cancel");

    // Idle timeout, plain and restarted by a GO byte.
    idle_run(-5, 104, "timeout");
    send(8'h67, 1'b1, 1'b0, 1'b0, "to_go");
    idle_run(50, 150, "timeout_go");

    // Asynchronous reset in STOP_WAIT with a GO byte already waiting.
    send(8'h67, 1'b1, 1'b0, 1'b0, "rst_go");
    send(8'h73, 1'b1, 1'b1, 1'b0, "rst_stop");
    #2;
    bus.rx_data = 8'h67;
    bus.rx_rdy  = 1'b1;
    rst         = 1'b1;
    #1;
    chk("async pwr",  pwr_up, 0);
    chk("async stop", stop_pend, 0);
    chk("async clr",  bus.clr_rx_rdy, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst clr",  bus.clr_rx_rdy, 1);
    chk("post_rst pwr",  pwr_up, 1);
    chk("post_rst stop", stop_pend, 0);
    bus.rx_rdy = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
